inst_fetch_unit: RTL and testbench

- Front end of the 16-bit-instruction datapath.
- Fetches one instruction at a time over a req/ack instruction-memory handshake and holds it in a single-entry buffer.
- Slices the buffered instruction into the raw fields consumed by the register-address/immediate mux stage: Rd0/Rd1, Rs0..Rs3, immed5/8/11.
- Redirects the fetch PC when the branch unit returns the sign-extended PC_offset16 with branch_taken.

---
 rtl/inst_fetch_unit_pkg.sv | 26 ++
 rtl/inst_fetch_unit_slice.sv | 32 +++
 rtl/inst_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: widths,
// FSM state encoding and instruction field bit positions.
package inst_fetch_unit_pkg;

  localparam int unsigned INST_W  = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned REG_W   = 3;

  localparam int unsigned RD0_LSB  = 0;
  localparam int unsigned RD1_LSB  = 8;
  localparam int unsigned RS0_LSB  = 3;
  localparam int unsigned RS1_LSB  = 6;
  localparam int unsigned RS2_LSB  = 0;
  localparam int unsigned RS3_LSB  = 8;
  localparam int unsigned IMM5_LSB = 6;
  localparam int unsigned IMM5_W   = 5;
  localparam int unsigned IMM8_W   = 8;
  localparam int unsigned IMM11_W  = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_slice.sv
// Purely combinational split of a buffered instruction word into the raw
// register/immediate fields used by the operand mux stage.
module inst_field_slice
  import inst_fetch_unit_pkg::*;
(
  input  logic [INST_W-1:0]  inst,
  output logic [REG_W-1:0]   Rd0,
  output logic [REG_W-1:0]   Rd1,
  output logic [REG_W-1:0]   Rs0,
  output logic [REG_W-1:0]   Rs1,
  output logic [REG_W-1:0]   Rs2,
  output logic [REG_W-1:0]   Rs3,
  output logic [IMM5_W-1:0]  immed5,
  output logic [IMM8_W-1:0]  immed8,
  output logic [IMM11_W-1:0] immed11
);

  // Opcode bits above the widest immediate are decoded elsewhere.
  logic unused_hi;

  assign Rd0       = inst[RD0_LSB +: REG_W];
  assign Rd1       = inst[RD1_LSB +: REG_W];
  assign Rs0       = inst[RS0_LSB +: REG_W];
  assign Rs1       = inst[RS1_LSB +: REG_W];
  assign Rs2       = inst[RS2_LSB +: REG_W];
  assign Rs3       = inst[RS3_LSB +: REG_W];
  assign immed5    = inst[IMM5_LSB +: IMM5_W];
  assign immed8    = inst[0 +: IMM8_W];
  assign immed11   = inst[0 +: IMM11_W];
  assign unused_hi = ^inst[INST_W-1:IMM11_W];

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-entry instruction fetch unit: req/ack fetch, one buffered
// instruction with field slicing, and branch redirect of the fetch PC.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INST_W-1:0]  imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [PC_W-1:0]    inst_pc,
  output logic [REG_W-1:0]   Rd0,
  output logic [REG_W-1:0]   Rd1,
  output logic [REG_W-1:0]   Rs0,
  output logic [REG_W-1:0]   Rs1,
  output logic [REG_W-1:0]   Rs2,
  output logic [REG_W-1:0]   Rs3,
  output logic [IMM5_W-1:0]  immed5,
  output logic [IMM8_W-1:0]  immed8,
  output logic [IMM11_W-1:0] immed11,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    PC_offset16
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              drop_q, drop_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic [PC_W-1:0]   target;

  assign target = inst_pc_q + 16'd2 + (PC_offset16 << 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_addr_q  <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      imem_addr_q  <= imem_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      drop_q       <= drop_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (imem_ack && !branch_taken && !drop_q) state_d = S_HOLD;
      S_HOLD:  if (branch_taken || inst_ready) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_addr_d  = imem_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;
    pend_pc_d    = pend_pc_q;
    case (state_q)
      S_REQ: begin
        // The address of an outstanding request is frozen; a redirect that
        // arrives before the ack is parked in pend_pc and applied on the ack.
        if (branch_taken) begin
          if (imem_ack) begin
            imem_addr_d = target;
            drop_d      = 1'b0;
          end else begin
            pend_pc_d = target;
            drop_d    = 1'b1;
          end
        end else if (imem_ack) begin
          if (drop_q) begin
            drop_d      = 1'b0;
            imem_addr_d = pend_pc_q;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = imem_addr_q;
            inst_valid_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          inst_valid_d = 1'b0;
          imem_addr_d  = target;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          imem_addr_d  = inst_pc_q + 16'd2;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req = (state_q == S_REQ);
  end

  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;

  inst_field_slice u_slice (
    .inst    (inst_q),
    .Rd0     (Rd0),
    .Rd1     (Rd1),
    .Rs0     (Rs0),
    .Rs1     (Rs1),
    .Rs2     (Rs2),
    .Rs3     (Rs3),
    .immed5  (immed5),
    .immed8  (immed8),
    .immed11 (immed11)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: the driver predicts the PC of the
// next delivered instruction, a monitor pops and checks on each delivery.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_pc;
  logic [2:0]  Rd0, Rd1, Rs0, Rs1, Rs2, Rs3;
  logic [4:0]  immed5;
  logic [7:0]  immed8;
  logic [10:0] immed11;
  logic        branch_taken;
  logic [15:0] PC_offset16;

  logic [15:0] mem [0:32767];
  logic [15:0] exp_q [$];
  logic [15:0] last_pc;
  logic [41:0] dut_fields;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign dut_fields = {Rd0, Rd1, Rs0, Rs1, Rs2, Rs3, immed5, immed8, immed11};

  inst_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_pc      (inst_pc),
    .Rd0          (Rd0),
    .Rd1          (Rd1),
    .Rs0          (Rs0),
    .Rs1          (Rs1),
    .Rs2          (Rs2),
    .Rs3          (Rs3),
    .immed5       (immed5),
    .immed8       (immed8),
    .immed11      (immed11),
    .branch_taken (branch_taken),
    .PC_offset16  (PC_offset16)
  );

  // Fields computed arithmetically from the instruction word.
  function automatic logic [41:0] fields_of(input logic [15:0] w);
    logic [31:0] x;
    x = {16'd0, w};
    return {3'(x & 7), 3'((x >> 8) & 7), 3'((x >> 3) & 7), 3'((x >> 6) & 7),
            3'(x & 7), 3'((x >> 8) & 7), 5'((x >> 6) & 31), 8'(x & 255),
            11'(x & 2047)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, update the model, advance one cycle.
  task automatic step(input bit ack, input bit rdy, input bit br, input logic [15:0] off);
    imem_ack     = ack & imem_req;
    imem_rdata   = (ack & imem_req) ? mem[imem_addr[15:1]] : 16'($urandom);
    inst_ready   = rdy;
    branch_taken = br;
    PC_offset16  = off;
    if (br && (inst_valid || imem_req)) begin
      if (imem_req && exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(last_pc + 16'd2 + (off << 1));
    end else if (rdy && inst_valid) begin
      exp_q.push_back(last_pc + 16'd2);
    end
    @(negedge clk);
  endtask

  task automatic run_until_valid(input string name);
    int unsigned n = 0;
    while (!inst_valid && n < 64) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      n++;
    end
    check(name, {63'd0, inst_valid}, 64'd1);
  endtask

  task automatic goto_pc(input logic [15:0] pc);
    logic [15:0] d;
    d = pc - last_pc - 16'd2;
    step(1'b0, 1'b1, 1'b1, {d[15], d[15:1]});
    run_until_valid("goto_valid");
    check("goto_pc", inst_pc, pc);
  endtask

  // Monitor: protocol rules plus scoreboard pop on every new delivery.
  initial begin
    logic        prev_req, prev_valid;
    logic [15:0] prev_addr, held_pc;
    prev_req = 1'b0; prev_valid = 1'b0; prev_addr = '0; held_pc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev_req = 1'b0;
        prev_valid = 1'b0;
        continue;
      end
      if (prev_req && !imem_ack) begin
        check("req_held", {63'd0, imem_req}, 64'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
      check("req_valid_excl", {63'd0, imem_req && inst_valid}, 64'd0);
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_delivery: got pc %h expected none", inst_pc);
        end else begin
          held_pc = exp_q.pop_front();
          last_pc = held_pc;
          check("deliver_pc", inst_pc, held_pc);
          check("deliver_fields", dut_fields, fields_of(mem[held_pc[15:1]]));
        end
      end else if (inst_valid) begin
        check("hold_pc", inst_pc, held_pc);
        check("hold_fields", dut_fields, fields_of(mem[held_pc[15:1]]));
      end
      prev_req   = imem_req;
      prev_valid = inst_valid;
      prev_addr  = imem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    reset_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    branch_taken = 1'b0; PC_offset16 = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4A3C;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    last_pc = 16'h0000;
    repeat (3) @(negedge clk);

    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_addr", imem_addr, 64'h0000);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_pc", inst_pc, 64'h0000);
    check("rst_fields", dut_fields, 64'd0);

    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("first_req", {63'd0, imem_req}, 64'd1);
    check("first_addr", imem_addr, 64'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("first_valid", {63'd0, inst_valid}, 64'd1);
    check("first_req_low", {63'd0, imem_req}, 64'd0);
    check("first_pc", inst_pc, 64'h0000);
    check("immed8", immed8, 64'h3C);
    check("immed11", immed11, 64'h23C);
    check("immed5", immed5, 64'h08);
    check("Rd0", Rd0, 64'd4);
    check("Rs0", Rs0, 64'd7);
    check("Rs1", Rs1, 64'd0);
    check("Rd1", Rd1, 64'd2);

    repeat (5) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      check("stall_req", {63'd0, imem_req}, 64'd0);
      check("stall_valid", {63'd0, inst_valid}, 64'd1);
    end

    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      check("seq_req", {63'd0, imem_req}, 64'd1);
      check("seq_addr", imem_addr, 64'(k * 2));
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      check("seq_pc", inst_pc, 64'(k * 2));
    end

    goto_pc(16'h0010);
    step(1'b0, 1'b1, 1'b1, 16'hFFFC);
    check("br_hold_req", {63'd0, imem_req}, 64'd1);
    check("br_hold_addr", imem_addr, 64'h000A);
    run_until_valid("br_hold_valid");
    check("br_hold_pc", inst_pc, 64'h000A);

    goto_pc(16'h0020);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("pend_addr0", imem_addr, 64'h0022);
    step(1'b0, 1'b0, 1'b1, 16'h0008);
    check("pend_addr1", imem_addr, 64'h0022);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("pend_addr2", imem_addr, 64'h0022);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("drop_valid", {63'd0, inst_valid}, 64'd0);
    check("drop_req", {63'd0, imem_req}, 64'd1);
    check("drop_addr", imem_addr, 64'h0032);
    run_until_valid("drop_next_valid");
    check("drop_next_pc", inst_pc, 64'h0032);

    goto_pc(16'hFFFE);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("wrap_addr", imem_addr, 64'h0000);
    run_until_valid("wrap_valid");

    repeat (600)
      step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 10) == 0, 16'($urandom));

    n = 0;
    while (!imem_req && n < 64) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      n++;
    end
    check("pre_reset_req", {63'd0, imem_req}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", {63'd0, imem_req}, 64'd0);
    check("async_rst_addr", imem_addr, 64'h0000);
    check("async_rst_valid", {63'd0, inst_valid}, 64'd0);
    check("async_rst_pc", inst_pc, 64'h0000);
    exp_q.delete();
    exp_q.push_back(16'h0000);
    last_pc = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;

    repeat (300)
      step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 10) == 0, 16'($urandom));
    run_until_valid("final_valid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
